// File: rtl/ov7670_cfg_pkg.sv
// Shared types and table markers for the OV7670 configuration sequencer.
package ov7670_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    ROM_WAIT,
    DECODE,
    SEND,
    WAIT_ACK,
    DELAY,
    DONE,
    ERROR
  } seq_state_t;

  localparam logic [15:0] CFG_END_MARK   = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY_MARK = 16'hFFF0;

  // The sequencer counts as running in every state except the three resting states.
  function automatic logic seq_active(seq_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/ov7670_config_seq_if.sv
// Write-request channel between the configuration sequencer and an SCCB master.
interface ov7670_config_seq_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_reg;
  logic [7:0] wr_val;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_valid, wr_reg, wr_val,
    input  wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  wr_valid, wr_reg, wr_val,
    output wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/cfg_delay_timer.sv
// Down-counter for delay markers: load starts a run of exactly DELAY_CYCLES cycles,
// the last of which has expired high.
module cfg_delay_timer #(
  parameter int DELAY_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAY_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);
endmodule

// File: rtl/ov7670_config_seq.sv
// OV7670 register-table sequencer: walks an external table and issues SCCB writes.
// Build option CFG_RETRY_EN: re-send a NACKed entry up to MAX_RETRY times, then abort.
//   state    | meaning
//   IDLE     | waiting for start after reset
//   FETCH    | table address presented
//   ROM_WAIT | table read in flight
//   DECODE   | classify entry: end marker, delay marker or write
//   SEND     | write offered to the SCCB master
//   WAIT_ACK | write accepted, waiting for completion
//   DELAY    | fixed settle time after a delay marker
//   DONE     | table finished
//   ERROR    | aborted on repeated NACK
module ov7670_config_seq
  import ov7670_cfg_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DELAY_CYCLES = 240000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [15:0]         rom_data,
  ov7670_config_seq_if.master wr,
  output logic                busy,
  output logic                done,
  output logic                error
);
  seq_state_t state, state_next;
  logic start_run, load_entry, advance, last_entry;
  logic delay_load, delay_expired;
  logic handshake, nack_retry, nack_abort;

  assign last_entry = (rom_addr == '1);
  assign handshake  = wr.wr_valid && wr.wr_ready;

  cfg_delay_timer #(
    .DELAY_CYCLES(DELAY_CYCLES)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .load   (delay_load),
    .expired(delay_expired)
  );

`ifdef CFG_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_left;

  assign retry_left = (retry_cnt < RETRY_W'(MAX_RETRY));
  assign nack_retry = wr.wr_done && wr.wr_nack && retry_left;
  assign nack_abort = wr.wr_done && wr.wr_nack && !retry_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt <= '0;
      error     <= 1'b0;
    end else begin
      if (start_run || advance) begin
        retry_cnt <= '0;
      end else if (state == WAIT_ACK && nack_retry) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end
      error <= (state_next == ERROR);
    end
  end
`else
  // NACK is not acted on in this build; every write counts as a success.
  logic unused_nack;
  assign unused_nack = wr.wr_nack ^ (MAX_RETRY > 0);
  assign nack_retry  = 1'b0;
  assign nack_abort  = 1'b0;
  assign error       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    start_run  = 1'b0;
    load_entry = 1'b0;
    advance    = 1'b0;
    delay_load = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          start_run  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH:    state_next = ROM_WAIT;
      ROM_WAIT: state_next = DECODE;
      DECODE: begin
        if (rom_data == CFG_END_MARK) begin
          state_next = DONE;
        end else if (rom_data == CFG_DELAY_MARK) begin
          delay_load = 1'b1;
          state_next = DELAY;
        end else begin
          load_entry = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (wr.wr_done) begin
          if (nack_retry)      state_next = SEND;
          else if (nack_abort) state_next = ERROR;
          else                 advance = 1'b1;
        end
      end
      DELAY: begin
        if (delay_expired) advance = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // The last table slot ends the run rather than wrapping to entry 0.
    if (advance) state_next = last_entry ? DONE : FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= '0;
      wr.wr_valid <= 1'b0;
      wr.wr_reg   <= '0;
      wr.wr_val   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      wr.wr_valid <= (state_next == SEND);
      busy        <= seq_active(state_next);
      done        <= (state_next == DONE);
      if (start_run) begin
        rom_addr <= '0;
      end else if (advance && !last_entry) begin
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (load_entry) begin
        wr.wr_reg <= rom_data[15:8];
        wr.wr_val <= rom_data[7:0];
      end
    end
  end
endmodule
